// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/ready register chain with bubble collapse,
// flush, occupancy count and a retire order counter.
// Optional feature macro: PIPE_SKID_EN adds a skid slot ahead of slot 0 so
// in_ready has no combinational path from out_ready.
module pipe_stage_chain #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_STAGES = 2,
    parameter int unsigned ORDER_W  = 64,
    localparam int unsigned OCC_W   = $clog2(N_STAGES + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [ORDER_W-1:0] out_order,
    output logic [OCC_W-1:0]   occupancy
);

    // Slot 0 is the input side, slot N_STAGES-1 is the head.
    logic [N_STAGES-1:0] r_v;
    logic [WIDTH-1:0]    r_d [N_STAGES];
    logic [ORDER_W-1:0]  r_order;
    logic [OCC_W-1:0]    r_occ;

    logic [N_STAGES-1:0] w_adv;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_src_v;
    logic [WIDTH-1:0]    w_src_d;

    // A slot advances when it or any slot ahead of it is empty, or the head drains.
    // Written as an OR over the downstream slots to avoid a self-referencing chain.
    always_comb begin
        w_adv = '0;
        for (int i = 0; i < int'(N_STAGES); i++) begin
            w_adv[i] = out_ready;
            for (int j = i; j < int'(N_STAGES); j++) begin
                if (!r_v[j]) begin
                    w_adv[i] = 1'b1;
                end
            end
        end
    end

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

`ifdef PIPE_SKID_EN
    logic             r_sv;
    logic [WIDTH-1:0] r_sd;

    // Registered ready: only the skid occupancy gates upstream.
    assign in_ready = !r_sv && !flush;

    // A parked skid entry always wins slot 0 over fresh input.
    assign w_src_v = r_sv || w_in_fire;
    assign w_src_d = r_sv ? r_sd : in_data;

    // Skid slot: park on accept while slot 0 is stalled, release when it advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sv <= 1'b0;
            r_sd <= '0;
        end else if (flush) begin
            r_sv <= 1'b0;
        end else if (r_sv) begin
            if (w_adv[0]) begin
                r_sv <= 1'b0;
            end
        end else if (w_in_fire && !w_adv[0]) begin
            r_sv <= 1'b1;
            r_sd <= in_data;
        end
    end
`else
    assign in_ready = w_adv[0] && !flush;
    assign w_src_v  = w_in_fire;
    assign w_src_d  = in_data;
`endif

    assign out_valid = r_v[N_STAGES-1] && !flush;
    assign out_data  = r_d[N_STAGES-1];
    assign out_order = r_order;
    assign occupancy = r_occ;

    // Valid bits: shift forward on advance, all cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else if (flush) begin
            r_v <= '0;
        end else begin
            if (w_adv[0]) begin
                r_v[0] <= w_src_v;
            end
            for (int i = 1; i < int'(N_STAGES); i++) begin
                if (w_adv[i]) begin
                    r_v[i] <= r_v[i-1];
                end
            end
        end
    end

    // Payload: load only when a valid entry arrives; otherwise hold (bubbles keep old data).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_STAGES); i++) begin
                r_d[i] <= '0;
            end
        end else if (!flush) begin
            if (w_adv[0] && w_src_v) begin
                r_d[0] <= w_src_d;
            end
            for (int i = 1; i < int'(N_STAGES); i++) begin
                if (w_adv[i] && r_v[i-1]) begin
                    r_d[i] <= r_d[i-1];
                end
            end
        end
    end

    // Retire order: counts consumes, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_order <= '0;
        end else if (w_out_fire) begin
            r_order <= r_order + ORDER_W'(1);
        end
    end

    // Occupancy: +1 per accept, -1 per consume, zero after flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_fire) - OCC_W'(w_out_fire);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (WIDTH=16, N_STAGES=2, ORDER_W=4).
// The reference model is a queue of in-flight entries, each tagged with the
// earliest cycle it may appear at the head. Build with +define+PIPE_SKID_EN
// to check the skid variant.
module tb_pipe_stage_chain;

    localparam int unsigned W  = 16;
    localparam int unsigned N  = 2;
    localparam int unsigned OW = 4;
    localparam int unsigned OCW = $clog2(N + 2);

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [OW-1:0]  out_order;
    logic [OCW-1:0] occupancy;

    pipe_stage_chain #(
        .WIDTH    (W),
        .N_STAGES (N),
        .ORDER_W  (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_order (out_order),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           rdy;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   cons   = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare DUT against the queue model every cycle, then advance the model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                q.delete();
                cons = 0;
            end else begin
                bit   exp_v;
                bit   exp_r;
                ent_t e;
                exp_v = !flush && (q.size() > 0) && (q[0].rdy <= cyc);
`ifdef PIPE_SKID_EN
                // Skid adds one more place; ready depends only on stored count.
                exp_r = !flush && (q.size() <= N);
`else
                exp_r = !flush && ((q.size() < N) || out_ready);
`endif
                chk("out_valid", 64'(out_valid), 64'(exp_v));
                chk("in_ready", 64'(in_ready), 64'(exp_r));
                chk("occupancy", 64'(occupancy), 64'(q.size()));
                chk("out_order", 64'(out_order), 64'(cons % (1 << OW)));
                if (exp_v) begin
                    chk("out_data", 64'(out_data), 64'(q[0].data));
                end
                if (exp_v && out_ready) begin
                    void'(q.pop_front());
                    cons++;
                    // The next entry can reach the head one cycle after this consume at the earliest.
                    if (q.size() > 0 && q[0].rdy < cyc + 1) begin
                        q[0].rdy = cyc + 1;
                    end
                end
                if (exp_r && in_valid) begin
                    e.data = in_data;
                    e.rdy  = cyc + N;
                    q.push_back(e);
                end
                if (flush) begin
                    q.delete();
                end
            end
        end
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_order", 64'(out_order), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Random traffic; a blocked offer is held stable until accepted.
    task automatic rand_phase(input int n, input int ordy_pct, input int fl_per);
        for (int k = 0; k < n; k++) begin
            logic         pend;
            logic         v;
            logic [W-1:0] d;
            @(negedge clk);
            pend = in_valid && !in_ready;
            if (pend) begin
                v = 1'b1;
                d = in_data;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                d = W'($urandom);
            end
            step(v, d, ($urandom_range(0, 99) < ordy_pct), ($urandom_range(0, fl_per - 1) == 0));
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_occupancy", 64'(occupancy), 64'd0);
        chk("init_out_order", 64'(out_order), 64'd0);
        chk("init_out_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Back-to-back stream with the sink always ready.
        step(1, 16'h000A, 1, 0);
        step(1, 16'h000B, 1, 0);
        step(1, 16'h000C, 1, 0);
        repeat (3) step(0, 16'h0, 1, 0);

        // Fill with the sink stalled, then one cycle of simultaneous accept and consume.
        step(1, 16'h0001, 0, 0);
        step(1, 16'h0002, 0, 0);
        step(1, 16'h0003, 0, 0);
        step(1, 16'h0003, 0, 0);
        step(1, 16'h0003, 1, 0);
        step(1, 16'h0004, 0, 0);
        step(1, 16'h0004, 0, 0);

        // Flush while full with both handshakes requested.
        step(1, 16'h0005, 1, 1);
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 0, 0);

        // Bubble collapse: head stalled, slot 0 empty, then more pushes.
        step(1, 16'h0001, 0, 0);
        step(0, 16'h0, 0, 0);
        step(0, 16'h0, 0, 0);
        step(1, 16'h0002, 0, 0);
        step(1, 16'h0003, 0, 0);
        step(1, 16'h0003, 0, 0);
        step(1, 16'h0003, 1, 0);
        repeat (5) step(0, 16'h0, 1, 0);

        // Random traffic across backpressure regimes, with a reset in the middle.
        rand_phase(300, 70, 30);
        rand_phase(200, 25, 40);
        do_reset();
        rand_phase(300, 90, 50);
        rand_phase(200, 50, 25);

        repeat (6) step(0, 16'h0, 1, 0);
        @(negedge clk);
        #1;
        chk("drained_occupancy", 64'(occupancy), 64'd0);
        chk("drained_out_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
